// File: rtl/ctx_stack.sv
// Hardware return stack of call/interrupt frames with sticky overflow/underflow; CTX_STACK_FLAGS_EN stores Z/C flags.
// Latency: push visible on top outputs after one edge, top read is combinational; no backpressure, requests are single-cycle pulses.
module ctx_stack #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 16,
  parameter int FLAG_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     push_int,
  input  logic                     pop,
  input  logic                     clr_err,
  input  logic [ADDR_W-1:0]        ret_addr,
  input  logic [FLAG_W-1:0]        flags_in,
  output logic [ADDR_W-1:0]        top_addr,
  output logic [FLAG_W-1:0]        top_flags,
  output logic                     top_is_int,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   int_level,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [LW-1:0]     sp, sp_nxt;
  logic [LW-1:0]     il, il_nxt;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DEPTH-1:0]  tag_mem;
  logic [PW-1:0]     top_idx, wr_idx;
  logic              p, we, new_tag, old_tag, ovf_evt, unf_evt;

  assign p       = push | push_int;
  assign new_tag = push_int;
  assign empty   = (sp == '0);
  assign full    = (sp == LW'(DEPTH));
  // When full, the low PW bits of sp are zero and the subtraction wraps to DEPTH-1.
  assign top_idx = sp[PW-1:0] - PW'(1);
  assign old_tag = ~empty & tag_mem[top_idx];

  assign level      = sp;
  assign int_level  = il;
  assign top_is_int = old_tag;
  assign top_addr   = empty ? '0 : addr_mem[top_idx];

  always_comb begin
    we      = 1'b0;
    wr_idx  = sp[PW-1:0];
    sp_nxt  = sp;
    il_nxt  = il;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (p && pop && !empty) begin
      // Replace the top frame in place.
      we     = 1'b1;
      wr_idx = top_idx;
      il_nxt = il + LW'(new_tag) - LW'(old_tag);
    end else if (p) begin
      unf_evt = pop;
      if (!full) begin
        we     = 1'b1;
        sp_nxt = sp + LW'(1);
        il_nxt = il + LW'(new_tag);
      end else begin
        ovf_evt = 1'b1;
      end
    end else if (pop) begin
      if (!empty) begin
        sp_nxt = sp - LW'(1);
        il_nxt = il - LW'(old_tag);
      end else begin
        unf_evt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp        <= '0;
      il        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_nxt;
      il        <= il_nxt;
      overflow  <= ovf_evt | (overflow & ~clr_err);
      underflow <= unf_evt | (underflow & ~clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && we) begin
      addr_mem[wr_idx] <= ret_addr;
      tag_mem[wr_idx]  <= new_tag;
    end
  end

`ifdef CTX_STACK_FLAGS_EN
  logic [FLAG_W-1:0] flag_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset && we) begin
      flag_mem[wr_idx] <= push_int ? flags_in : '0;
    end
  end

  assign top_flags = old_tag ? flag_mem[top_idx] : '0;
`else
  logic unused_flags;
  assign unused_flags = ^flags_in;
  assign top_flags    = '0;
`endif

endmodule
